md_sched: RTL

MD_SCHED -- requirements
Module: md_sched

---
 rtl/md_sched.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/md_sched.sv
// HI/LO scheduler for a MIPS-style pipeline: multi-cycle MULT/DIV with busy/stall
// generation, immediate MTHI/MTLO, and deferred commit of pending results.
module md_sched #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;
  logic [31:0]        pend_hi_q;
  logic [31:0]        pend_lo_q;
  logic               pend_ok_q;

  logic               is_mul_op;
  logic               is_div_op;
  logic [63:0]        mul_a_ext;
  logic [63:0]        mul_b_ext;
  logic [63:0]        product;
  logic               a_neg;
  logic               b_neg;
  logic [31:0]        a_mag;
  logic [31:0]        b_mag;
  logic [31:0]        divisor;
  logic [31:0]        quo_mag;
  logic [31:0]        rem_mag;
  logic [31:0]        quotient;
  logic [31:0]        remainder;
  logic [31:0]        pend_hi_d;
  logic [31:0]        pend_lo_d;

  assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div_op = (op == OP_DIV)  || (op == OP_DIVU);

  // Low 64 bits of a 64x64 product of sign- or zero-extended operands give the
  // exact 32x32 result for both signed and unsigned multiplies.
  always_comb begin
    mul_a_ext = {32'b0, a};
    mul_b_ext = {32'b0, b};
    if (op == OP_MULT) begin
      mul_a_ext = {{32{a[31]}}, a};
      mul_b_ext = {{32{b[31]}}, b};
    end
    product = mul_a_ext * mul_b_ext;
  end

  // Signed division on magnitudes: quotient truncates toward zero and the
  // remainder carries the dividend's sign. A zero divisor is replaced by 1 only
  // to keep the datapath defined; its result is never committed.
  always_comb begin
    a_neg     = (op == OP_DIV) && a[31];
    b_neg     = (op == OP_DIV) && b[31];
    a_mag     = a_neg ? (~a + 32'd1) : a;
    b_mag     = b_neg ? (~b + 32'd1) : b;
    divisor   = (b_mag == 32'd0) ? 32'd1 : b_mag;
    quo_mag   = a_mag / divisor;
    rem_mag   = a_mag % divisor;
    quotient  = (a_neg ^ b_neg) ? (~quo_mag + 32'd1) : quo_mag;
    remainder = a_neg ? (~rem_mag + 32'd1) : rem_mag;
  end

  always_comb begin
    pend_hi_d = product[63:32];
    pend_lo_d = product[31:0];
    if (is_div_op) begin
      pend_hi_d = remainder;
      pend_lo_d = quotient;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_ok_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (is_mul_op) begin
              pend_hi_q <= pend_hi_d;
              pend_lo_q <= pend_lo_d;
              pend_ok_q <= 1'b1;
              cnt_q     <= CNT_W'(MUL_CYCLES);
              busy_q    <= 1'b1;
              state_q   <= S_MUL;
            end else if (is_div_op) begin
              pend_hi_q <= pend_hi_d;
              pend_lo_q <= pend_lo_d;
              pend_ok_q <= (b != 32'd0);
              cnt_q     <= CNT_W'(DIV_CYCLES);
              busy_q    <= 1'b1;
              state_q   <= S_DIV;
            end else if (op == OP_MTHI) begin
              hi_q <= a;
            end else if (op == OP_MTLO) begin
              lo_q <= a;
            end
          end
        end
        S_MUL, S_DIV: begin
          // start is deliberately ignored here, so commit never races a new op
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
            if (pend_ok_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
          end
        end
        default: begin
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = md_use & (busy_q | (start & (is_mul_op | is_div_op)));

endmodule
